regfile_wb_scheduler: RTL and testbench

- Sequences access to the 32x32 integer register file, which has one write port.
- Arbitrates up to NUM_WB writeback sources (ALU, load unit, CSR unit) onto that port using round-robin priority and valid/ready handshakes.
- Keeps a busy-register scoreboard. Issue stalls on RAW and WAW hazards until the pending write has committed.
- Sits between the decode/issue stage, the execution units and the register file.

---
 rtl/rv_core_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 59 +++++
 rtl/regfile_wb_scheduler.sv | 125 ++++++++++++
 tb/tb_regfile_wb_scheduler.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_core_pkg.sv
// Shared integer-core definitions used by the register file writeback path.
//   XLEN      : integer data width
//   AW        : architectural register address width (32 registers)
//   reg_addr_t: register address type
//   REG_ZERO  : hard-wired zero register x0
package rv_core_pkg;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    typedef logic [AW-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter for the register file write port.
// Ports:
//   clk, reset : clock, synchronous active-low reset (pointer returns to 0)
//   req        : per-requester request vector
//   advance    : a grant was taken this cycle; move the pointer past it
//   grant      : one-hot grant (all zero when nothing is requested)
//   idx        : binary index of the granted requester
module rr_arbiter #(
    parameter  int NUM_WB = 3,
    localparam int IW     = (NUM_WB > 1) ? $clog2(NUM_WB) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_WB-1:0] req,
    input  logic              advance,
    output logic [NUM_WB-1:0] grant,
    output logic [IW-1:0]     idx
);

    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] rr_ptr_next;
    logic [IW:0]   cand;
    logic          found;

    // Scan from rr_ptr upward, wrapping modulo NUM_WB; first requester wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < NUM_WB; k++) begin
            cand = {1'b0, rr_ptr} + (IW+1)'(k);
            if (cand >= (IW+1)'(NUM_WB)) begin
                cand = cand - (IW+1)'(NUM_WB);
            end
            if (!found && req[cand[IW-1:0]]) begin
                found                 = 1'b1;
                grant[cand[IW-1:0]]   = 1'b1;
                idx                   = cand[IW-1:0];
            end
        end
    end

    always_comb begin
        rr_ptr_next = rr_ptr;
        if (advance) begin
            rr_ptr_next = (idx == IW'(NUM_WB - 1)) ? '0 : idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr <= '0;
        end else begin
            rr_ptr <= rr_ptr_next;
        end
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Register file write-port scheduler with busy-register scoreboard.
// Ports:
//   clk, reset        : clock, synchronous active-low reset
//   issue_*           : instruction presented by decode (sources, destination)
//   issue_stall       : instruction cannot issue this cycle (RAW/WAW on a busy register)
//   wb_valid/rd/data  : packed writeback requests, requester i at slice i
//   wb_ready          : one-hot grant to the writeback requesters
//   rf_we/rf_rd/rf_data : registered write into the register file (1 cycle after transfer)
//   busy_mask         : scoreboard, one bit per architectural register, bit 0 always 0
//
// Handshake: requester i transfers when wb_valid[i] & wb_ready[i] at a rising edge.
// Once valid is raised, valid/rd/data stay stable until that transfer; ready may
// depend combinationally on valid. No transfer is ever granted while reset is low.
module regfile_wb_scheduler #(
    parameter  int NUM_WB = 3,
    parameter  int XLEN   = rv_core_pkg::XLEN,
    parameter  int AW     = rv_core_pkg::AW,
    localparam int NREG   = 1 << AW,
    localparam int IW     = (NUM_WB > 1) ? $clog2(NUM_WB) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   issue_valid,
    input  logic [AW-1:0]          issue_rs1,
    input  logic [AW-1:0]          issue_rs2,
    input  logic                   issue_use_rs1,
    input  logic                   issue_use_rs2,
    input  logic [AW-1:0]          issue_rd,
    input  logic                   issue_wr,
    output logic                   issue_stall,
    input  logic [NUM_WB-1:0]      wb_valid,
    input  logic [NUM_WB*AW-1:0]   wb_rd,
    input  logic [NUM_WB*XLEN-1:0] wb_data,
    output logic [NUM_WB-1:0]      wb_ready,
    output logic                   rf_we,
    output logic [AW-1:0]          rf_rd,
    output logic [XLEN-1:0]        rf_data,
    output logic [NREG-1:0]        busy_mask
);

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;
    logic [IW-1:0]   grant_idx;
    logic            transfer;
    logic            issue_fire;
    logic            issue_set;
    logic            we_q;
    logic [AW-1:0]   sel_rd;
    logic [XLEN-1:0] sel_data;

    // Reset masks requests so nothing is granted (and nothing transfers) in a reset cycle.
    rr_arbiter #(.NUM_WB(NUM_WB)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (wb_valid & {NUM_WB{reset}}),
        .advance (transfer),
        .grant   (wb_ready),
        .idx     (grant_idx)
    );

    assign transfer = |wb_ready;
    assign sel_rd   = wb_rd[int'(grant_idx)*AW +: AW];
    assign sel_data = wb_data[int'(grant_idx)*XLEN +: XLEN];

    // No bypass: a source or destination marked busy blocks issue outright.
    assign issue_stall = issue_valid & ((issue_use_rs1 & busy[issue_rs1]) |
                                        (issue_use_rs2 & busy[issue_rs2]) |
                                        (issue_wr      & busy[issue_rd]));
    assign issue_fire  = issue_valid & ~issue_stall;
    assign issue_set   = issue_fire & issue_wr & (issue_rd != rv_core_pkg::REG_ZERO);

    // Clear first, then set, so a same-edge set of the same register wins.
    always_comb begin
        busy_next = busy;
        if (rf_we) begin
            busy_next[rf_rd] = 1'b0;
        end
        if (issue_set) begin
            busy_next[issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // Write stage: a transfer to x0 is consumed but never reaches the file.
    always_ff @(posedge clk) begin
        if (!reset) begin
            we_q    <= 1'b0;
            rf_rd   <= '0;
            rf_data <= '0;
        end else if (transfer) begin
            we_q    <= (sel_rd != rv_core_pkg::REG_ZERO);
            rf_rd   <= sel_rd;
            rf_data <= sel_data;
        end else begin
            we_q    <= 1'b0;
        end
    end

    // A write in flight when reset is asserted must not commit.
    assign rf_we     = we_q & reset;
    assign busy_mask = busy;

    for (genvar i = 0; i < NUM_WB; i++) begin : g_hold_chk
        a_hold_valid: assert property (@(posedge clk)
            (reset && wb_valid[i] && !wb_ready[i]) |=> (!reset || wb_valid[i]))
            else $error("writeback requester %0d dropped valid before grant", i);
    end

    a_set_clear: assert property (@(posedge clk)
        !(reset && rf_we && issue_set && (issue_rd == rf_rd)))
        else $error("busy set and clear of x%0d on the same edge", rf_rd);

    a_stray_wb: assert property (@(posedge clk)
        !(reset && rf_we && !busy[rf_rd]))
        else $warning("writeback to non-busy register x%0d", rf_rd);

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
module tb_regfile_wb_scheduler;

    localparam int NUM_WB = 3;
    localparam int XLEN   = 32;
    localparam int AW     = 5;

    logic                   clk;
    logic                   reset;
    logic                   issue_valid;
    logic [AW-1:0]          issue_rs1;
    logic [AW-1:0]          issue_rs2;
    logic                   issue_use_rs1;
    logic                   issue_use_rs2;
    logic [AW-1:0]          issue_rd;
    logic                   issue_wr;
    logic                   issue_stall;
    logic [NUM_WB-1:0]      wb_valid;
    logic [NUM_WB*AW-1:0]   wb_rd;
    logic [NUM_WB*XLEN-1:0] wb_data;
    logic [NUM_WB-1:0]      wb_ready;
    logic                   rf_we;
    logic [AW-1:0]          rf_rd;
    logic [XLEN-1:0]        rf_data;
    logic [31:0]            busy_mask;

    int n_checks = 0;
    int n_pass   = 0;

    // Expected register file writes, {rd, data}, in commit order.
    logic [AW+XLEN-1:0] exp_q[$];

    regfile_wb_scheduler #(.NUM_WB(NUM_WB), .XLEN(XLEN), .AW(AW)) dut (
        .clk           (clk),
        .reset         (reset),
        .issue_valid   (issue_valid),
        .issue_rs1     (issue_rs1),
        .issue_rs2     (issue_rs2),
        .issue_use_rs1 (issue_use_rs1),
        .issue_use_rs2 (issue_use_rs2),
        .issue_rd      (issue_rd),
        .issue_wr      (issue_wr),
        .issue_stall   (issue_stall),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .wb_ready      (wb_ready),
        .rf_we         (rf_we),
        .rf_rd         (rf_rd),
        .rf_data       (rf_data),
        .busy_mask     (busy_mask)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] rd,
                           input logic [XLEN-1:0] d);
        wb_valid[i]            = v;
        wb_rd[i*AW +: AW]      = rd;
        wb_data[i*XLEN +: XLEN] = d;
    endtask

    task automatic set_issue(input logic v, input logic [AW-1:0] rd, input logic wr,
                             input logic [AW-1:0] rs1, input logic use1);
        issue_valid   = v;
        issue_rd      = rd;
        issue_wr      = wr;
        issue_rs1     = rs1;
        issue_use_rs1 = use1;
        issue_rs2     = 5'd0;
        issue_use_rs2 = 1'b0;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [AW+XLEN-1:0] e;
        if (rf_we === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_write: unexpected rf write rd=%0d data=%h, none expected", rf_rd, rf_data);
            end else begin
                e = exp_q.pop_front();
                if ({rf_rd, rf_data} !== e)
                    $display("FAIL sb_write: got rd=%0d data=%h expected rd=%0d data=%h",
                             rf_rd, rf_data, e[AW+XLEN-1:XLEN], e[XLEN-1:0]);
                else
                    n_pass++;
            end
        end
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        set_issue(1'b1, 5'd5, 1'b1, 5'd0, 1'b0);
        for (int i = 0; i < NUM_WB; i++) set_req(i, 1'b1, 5'd0, 32'h0);
        @(negedge clk);
        n_checks++; if (wb_ready !== 3'b000) $display("FAIL rst_ready_in_reset: got %b expected 000", wb_ready); else n_pass++;
        tick(); tick();
        reset = 1'b1;
        issue_valid = 1'b0;
        wb_valid = '0;
        @(negedge clk);
        n_checks++; if (busy_mask !== 32'h0) $display("FAIL rst_busy: got %h expected 0", busy_mask); else n_pass++;
        n_checks++; if (rf_we !== 1'b0) $display("FAIL rst_we: got %b expected 0", rf_we); else n_pass++;
        n_checks++; if (wb_ready !== 3'b000) $display("FAIL rst_ready: got %b expected 000", wb_ready); else n_pass++;
        tick();
        set_req(0, 1'b1, 5'd0, 32'h11);
        set_req(1, 1'b1, 5'd0, 32'h22);
        set_req(2, 1'b1, 5'd0, 32'h33);
        @(negedge clk);
        n_checks++; if (wb_ready !== 3'b001) $display("FAIL rst_first_grant: got %b expected 001", wb_ready); else n_pass++;
        tick(); set_req(0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        n_checks++; if (wb_ready !== 3'b010) $display("FAIL rst_grant1: got %b expected 010", wb_ready); else n_pass++;
        tick(); set_req(1, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        n_checks++; if (wb_ready !== 3'b100) $display("FAIL rst_grant2: got %b expected 100", wb_ready); else n_pass++;
        tick(); set_req(2, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        n_checks++; if (wb_ready !== 3'b000) $display("FAIL rst_idle: got %b expected 000", wb_ready); else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [XLEN-1:0] d [4];
        for (int i = 0; i < 4; i++) d[i] = $urandom();
        for (int r = 1; r <= 4; r++) begin
            tick();
            set_issue(1'b1, AW'(r), 1'b1, 5'd0, 1'b0);
            @(negedge clk);
            n_checks++; if (issue_stall !== 1'b0) $display("FAIL rr_issue_%0d: stall got %b expected 0", r, issue_stall); else n_pass++;
        end
        tick();
        issue_valid = 1'b0;
        set_req(0, 1'b1, 5'd1, d[0]); exp_q.push_back({5'd1, d[0]});
        set_req(1, 1'b1, 5'd2, d[1]); exp_q.push_back({5'd2, d[1]});
        set_req(2, 1'b1, 5'd3, d[2]); exp_q.push_back({5'd3, d[2]});
        @(negedge clk);
        n_checks++; if (busy_mask !== 32'h1E) $display("FAIL rr_busy: got %h expected 0000001e", busy_mask); else n_pass++;
        n_checks++; if (wb_ready !== 3'b001) $display("FAIL rr_g0: got %b expected 001", wb_ready); else n_pass++;
        tick();
        set_req(0, 1'b1, 5'd4, d[3]); exp_q.push_back({5'd4, d[3]});
        @(negedge clk);
        n_checks++; if (wb_ready !== 3'b010) $display("FAIL rr_g1: got %b expected 010", wb_ready); else n_pass++;
        tick(); set_req(1, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        n_checks++; if (wb_ready !== 3'b100) $display("FAIL rr_g2: got %b expected 100", wb_ready); else n_pass++;
        tick(); set_req(2, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        n_checks++; if (wb_ready !== 3'b001) $display("FAIL rr_g0_again: got %b expected 001", wb_ready); else n_pass++;
        tick(); set_req(0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        n_checks++; if (wb_ready !== 3'b000) $display("FAIL rr_idle: got %b expected 000", wb_ready); else n_pass++;
        tick();
        @(negedge clk);
        n_checks++; if (busy_mask !== 32'h0) $display("FAIL rr_busy_clear: got %h expected 0", busy_mask); else n_pass++;
    endtask

    task automatic test_x0_wb();
        tick();
        set_req(1, 1'b1, 5'd0, 32'h1234);
        @(negedge clk);
        n_checks++; if (wb_ready !== 3'b010) $display("FAIL x0_ready: got %b expected 010", wb_ready); else n_pass++;
        tick(); set_req(1, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        n_checks++; if (rf_we !== 1'b0) $display("FAIL x0_we: got %b expected 0", rf_we); else n_pass++;
        n_checks++; if (busy_mask !== 32'h0) $display("FAIL x0_busy: got %h expected 0", busy_mask); else n_pass++;
    endtask

    task automatic test_raw();
        tick();
        set_issue(1'b1, 5'd5, 1'b1, 5'd0, 1'b0);
        @(negedge clk);
        n_checks++; if (issue_stall !== 1'b0) $display("FAIL raw_issue_rd: stall got %b expected 0", issue_stall); else n_pass++;
        tick();
        set_issue(1'b1, 5'd0, 1'b0, 5'd5, 1'b1);
        set_req(0, 1'b1, 5'd5, 32'hDEADBEEF); exp_q.push_back({5'd5, 32'hDEADBEEF});
        @(negedge clk);
        n_checks++; if (issue_stall !== 1'b1) $display("FAIL raw_stall_t: got %b expected 1", issue_stall); else n_pass++;
        n_checks++; if (busy_mask !== 32'h20) $display("FAIL raw_busy: got %h expected 00000020", busy_mask); else n_pass++;
        n_checks++; if (wb_ready !== 3'b001) $display("FAIL raw_grant: got %b expected 001", wb_ready); else n_pass++;
        tick(); set_req(0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        n_checks++; if (issue_stall !== 1'b1) $display("FAIL raw_stall_t1: got %b expected 1", issue_stall); else n_pass++;
        n_checks++; if (rf_we !== 1'b1) $display("FAIL raw_we: got %b expected 1", rf_we); else n_pass++;
        n_checks++; if (rf_rd !== 5'd5) $display("FAIL raw_rd: got %0d expected 5", rf_rd); else n_pass++;
        n_checks++; if (rf_data !== 32'hDEADBEEF) $display("FAIL raw_data: got %h expected deadbeef", rf_data); else n_pass++;
        tick();
        @(negedge clk);
        n_checks++; if (issue_stall !== 1'b0) $display("FAIL raw_unstall_t2: got %b expected 0", issue_stall); else n_pass++;
        n_checks++; if (busy_mask !== 32'h0) $display("FAIL raw_busy_clear: got %h expected 0", busy_mask); else n_pass++;
        tick();
        set_issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic test_waw();
        set_issue(1'b1, 5'd7, 1'b1, 5'd0, 1'b0);
        @(negedge clk);
        n_checks++; if (issue_stall !== 1'b0) $display("FAIL waw_first: stall got %b expected 0", issue_stall); else n_pass++;
        tick();
        @(negedge clk);
        n_checks++; if (issue_stall !== 1'b1) $display("FAIL waw_second_stall: got %b expected 1", issue_stall); else n_pass++;
        n_checks++; if (busy_mask !== 32'h80) $display("FAIL waw_busy: got %h expected 00000080", busy_mask); else n_pass++;
        tick();
        set_req(2, 1'b1, 5'd7, 32'hC0FFEE01); exp_q.push_back({5'd7, 32'hC0FFEE01});
        @(negedge clk);
        n_checks++; if (issue_stall !== 1'b1) $display("FAIL waw_stall_grant: got %b expected 1", issue_stall); else n_pass++;
        n_checks++; if (wb_ready !== 3'b100) $display("FAIL waw_grant: got %b expected 100", wb_ready); else n_pass++;
        tick(); set_req(2, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        n_checks++; if (issue_stall !== 1'b1) $display("FAIL waw_stall_commit: got %b expected 1", issue_stall); else n_pass++;
        n_checks++; if (rf_we !== 1'b1) $display("FAIL waw_we: got %b expected 1", rf_we); else n_pass++;
        tick();
        @(negedge clk);
        n_checks++; if (issue_stall !== 1'b0) $display("FAIL waw_unstall: got %b expected 0", issue_stall); else n_pass++;
        tick();
        issue_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (busy_mask !== 32'h80) $display("FAIL waw_reset_busy: got %h expected 00000080", busy_mask); else n_pass++;
        tick();
        set_req(0, 1'b1, 5'd7, 32'h77); exp_q.push_back({5'd7, 32'h77});
        @(negedge clk);
        n_checks++; if (wb_ready !== 3'b001) $display("FAIL waw_drain_grant: got %b expected 001", wb_ready); else n_pass++;
        tick(); set_req(0, 1'b0, 5'd0, 32'h0);
        tick();
        @(negedge clk);
        n_checks++; if (busy_mask !== 32'h0) $display("FAIL waw_drain_busy: got %h expected 0", busy_mask); else n_pass++;
    endtask

    task automatic test_reset_mid();
        tick();
        set_issue(1'b1, 5'd9, 1'b1, 5'd0, 1'b0);
        @(negedge clk);
        n_checks++; if (issue_stall !== 1'b0) $display("FAIL rmid_issue: stall got %b expected 0", issue_stall); else n_pass++;
        tick();
        issue_valid = 1'b0;
        set_req(1, 1'b1, 5'd9, 32'h99);
        @(negedge clk);
        n_checks++; if (wb_ready !== 3'b010) $display("FAIL rmid_grant: got %b expected 010", wb_ready); else n_pass++;
        tick();
        set_req(1, 1'b0, 5'd0, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (rf_we !== 1'b0) $display("FAIL rmid_we_in_reset: got %b expected 0", rf_we); else n_pass++;
        tick();
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (busy_mask !== 32'h0) $display("FAIL rmid_busy: got %h expected 0", busy_mask); else n_pass++;
        n_checks++; if (rf_we !== 1'b0) $display("FAIL rmid_we: got %b expected 0", rf_we); else n_pass++;
        n_checks++; if (wb_ready !== 3'b000) $display("FAIL rmid_ready: got %b expected 000", wb_ready); else n_pass++;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset         = 1'b0;
        issue_valid   = 1'b0;
        issue_rs1     = '0;
        issue_rs2     = '0;
        issue_use_rs1 = 1'b0;
        issue_use_rs2 = 1'b0;
        issue_rd      = '0;
        issue_wr      = 1'b0;
        wb_valid      = '0;
        wb_rd         = '0;
        wb_data       = '0;

        test_reset();
        test_round_robin();
        test_x0_wb();
        test_raw();
        test_waw();
        test_reset_mid();

        tick();
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL sb_drain: %0d writes outstanding, expected 0", exp_q.size());
        else n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
